// File: rtl/mul32_seq.sv
// Unsigned shift-add multiplier using an external combinational adder; done pulses WIDTH+1 cycles after start.
// No backpressure: start is only sampled in IDLE and ignored while busy.
module mul32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_m,
  input  logic [WIDTH-1:0]     add_s,
  input  logic                 add_cf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          hi_d    = '0;
          lo_d    = b;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Carry-out enters hi MSB and the adder LSB shifts into lo, so no bit is lost.
        hi_d  = {add_cf, add_s[WIDTH-1:1]};
        lo_d  = {add_s[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = {add_cf, add_s, lo_q[WIDTH-1:1]};
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign add_a   = hi_q;
  assign add_b   = lo_q[0] ? mcand_q : '0;
  assign add_m   = 1'b0;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Bench for mul32_seq: behavioural external adder plus a*b reference checks.
module tb_mul32_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_m;
  logic [31:0] add_s;
  logic        add_cf;

  int tests_run;
  int tests_failed;

  mul32_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_m(add_m),
    .add_s(add_s), .add_cf(add_cf)
  );

  // 32-bit add/sub unit: m=0 adds, m=1 subtracts (A + ~B + 1).
  logic [32:0] adder_sum;
  assign adder_sum = add_m ? ({1'b0, add_a} + {1'b0, ~add_b} + 33'd1)
                           : ({1'b0, add_a} + {1'b0, add_b});
  assign add_s  = adder_sum[31:0];
  assign add_cf = adder_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Starts one operation from IDLE; edges counts rising edges from the accept edge (1) to done visible.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        output logic [63:0] got, output int edges, output bit timed_out);
    got = '0;
    edges = 0;
    timed_out = 1'b1;
    @(negedge clk);
    a = ta;
    b = tb_v;
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      edges++;
      if (i == 0) begin
        #1;
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        got = product;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", busy, done);
    end
    tests_run++;
    if (product !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_product got=%h required=%h", product, 64'd0);
    end
    tests_run++;
    if (add_a !== 32'd0 || add_b !== 32'd0 || add_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_adder_ports add_a=%h add_b=%h add_m=%b required all 0", add_a, add_b, add_m);
    end
  endtask

  task automatic test_basic();
    logic [63:0] got;
    int edges;
    bit to;
    run_op(32'd3, 32'd5, got, edges, to);
    tests_run++;
    if (to || edges != 33) begin
      tests_failed++;
      $display("FAIL t1_latency edges=%0d timeout=%0d required edges=33", edges, to);
    end
    tests_run++;
    if (got !== 64'h0000_0000_0000_000F) begin
      tests_failed++;
      $display("FAIL t1_product got=%h required=%h", got, 64'hF);
    end
    // product must hold with done low after returning to IDLE
    repeat (5) @(negedge clk);
    tests_run++;
    if (product !== 64'hF || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_hold product=%h done=%b busy=%b required product=f done=0 busy=0", product, done, busy);
    end
  endtask

  task automatic test_max();
    logic [63:0] got;
    int edges;
    bit to;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, got, edges, to);
    tests_run++;
    if (to || got !== 64'hFFFF_FFFE_0000_0001) begin
      tests_failed++;
      $display("FAIL t2_max got=%h timeout=%0d required=%h", got, to, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_edges();
    logic [63:0] got;
    int edges;
    bit to;
    run_op(32'd0, 32'h1234_5678, got, edges, to);
    tests_run++;
    if (to || got !== 64'd0) begin
      tests_failed++;
      $display("FAIL t3_zero got=%h timeout=%0d required=%h", got, to, 64'd0);
    end
    run_op(32'h8000_0000, 32'd2, got, edges, to);
    tests_run++;
    if (to || got !== 64'h0000_0001_0000_0000) begin
      tests_failed++;
      $display("FAIL t3_msb got=%h timeout=%0d required=%h", got, to, 64'h0000_0001_0000_0000);
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] xa, xb;
    logic [63:0] got;
    int pulses;
    xa = $urandom;
    xb = $urandom;
    pulses = 0;
    got = '0;
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        got = product;
      end
      start = (i == 5 || i == 12 || done) ? 1'b1 : 1'b0;
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0;
    tests_run++;
    if (pulses != 1) begin
      tests_failed++;
      $display("FAIL t4_done_count got=%0d required=1", pulses);
    end
    tests_run++;
    if (got !== ref_mul(xa, xb)) begin
      tests_failed++;
      $display("FAIL t4_product got=%h required=%h", got, ref_mul(xa, xb));
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_idle busy=%b required=0", busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] got;
    int edges;
    bit to;
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_running busy=%b required=1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      tests_failed++;
      $display("FAIL t5_after_rst busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    run_op(32'd7, 32'd9, got, edges, to);
    tests_run++;
    if (to || got !== 64'd63 || edges != 33) begin
      tests_failed++;
      $display("FAIL t5_restart got=%h edges=%0d timeout=%0d required=%h edges=33", got, edges, to, 64'd63);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[3];
    logic [31:0] qb[3];
    int t_done[3];
    logic [63:0] got[3];
    int n;
    int cyc;
    for (int k = 0; k < 3; k++) begin
      qa[k] = $urandom;
      qb[k] = $urandom;
      t_done[k] = 0;
      got[k] = '0;
    end
    n = 0;
    cyc = 0;
    @(negedge clk);
    a = qa[0];
    b = qb[0];
    start = 1'b1;
    while (n < 3 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        got[n] = product;
        t_done[n] = cyc;
        n++;
        if (n < 3) begin
          a = qa[n];
          b = qb[n];
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (n != 3) begin
      tests_failed++;
      $display("FAIL t6_b2b_count got=%0d required=3", n);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (got[k] !== ref_mul(qa[k], qb[k])) begin
        tests_failed++;
        $display("FAIL t6_b2b_product[%0d] got=%h required=%h", k, got[k], ref_mul(qa[k], qb[k]));
      end
    end
    for (int k = 1; k < 3; k++) begin
      tests_run++;
      if (t_done[k] - t_done[k-1] != 34) begin
        tests_failed++;
        $display("FAIL t6_b2b_spacing[%0d] got=%0d required=34", k, t_done[k] - t_done[k-1]);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [63:0] got;
    int edges;
    bit to;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFF_FFFF;
      if (i % 70 == 0) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, got, edges, to);
      tests_run++;
      if (to || got !== ref_mul(ra, rb) || edges != 33) begin
        tests_failed++;
        $display("FAIL rand[%0d] a=%h b=%h got=%h edges=%0d required=%h edges=33", i, ra, rb, got, edges, ref_mul(ra, rb));
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_basic();
    test_max();
    test_edges();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
